// File: rtl/prog_pulse_gen_pkg.sv
// rtl/prog_pulse_gen_pkg.sv - shared types and constants for the programmable pulse generator
package prog_pulse_gen_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // 1 Hz square wave from a 100 MHz system clock
  localparam int unsigned DEFAULT_DIV = 50_000_000;

  // Channel index width; a single channel still gets a 1-bit select port
  function automatic int unsigned ch_idx_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// rtl/pulse_gen_ch.sv - one divider channel with shadowed, wrap-aligned retuning
module pulse_gen_ch
  import prog_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned RST_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  mode_e            wr_mode,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RST_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  mode_e            mode_q, mode_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic wrap;
  logic apply;

  // >= rather than == so a counter stranded above a freshly shrunk divisor wraps at once
  assign wrap  = en && (cnt_q >= (div_q - ONE));
  // A disabled channel has no wrap to wait for, so its shadow lands immediately
  assign apply = pend_q && (sync || !en || wrap);

  // Next-state: counter/outputs first, then shadow hand-over, then new shadow capture
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    sh_div_d  = sh_div_q;
    mode_d    = mode_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;

    if (sync || !en) begin
      cnt_d     = '0;
      tick_d    = 1'b0;
      clk_out_d = 1'b0;
    end else if (wrap) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = (mode_q == MODE_SQUARE) ? ~clk_out_q : 1'b1;
    end else begin
      cnt_d     = cnt_q + ONE;
      tick_d    = 1'b0;
      clk_out_d = (mode_q == MODE_SQUARE) ? clk_out_q : 1'b0;
    end

    // The closing wrap above used the old divisor; the new one governs from here on
    if (apply) begin
      div_d  = sh_div_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
      if (sh_mode_q != mode_q) begin
        clk_out_d = 1'b0;
      end
    end

    // Only offered when pend_q is clear, so this never clobbers an unapplied shadow
    if (wr_en) begin
      sh_div_d  = wr_div;
      sh_mode_d = wr_mode;
      pend_d    = 1'b1;
    end
  end

  // Channel state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      sh_div_q  <= DIV_RST;
      mode_q    <= MODE_SQUARE;
      sh_mode_q <= MODE_SQUARE;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sh_div_q  <= sh_div_d;
      mode_q    <= mode_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_pulse_gen.sv
// rtl/prog_pulse_gen.sv - multi-channel programmable clock divider / tick generator
module prog_pulse_gen
  import prog_pulse_gen_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = prog_pulse_gen_pkg::DEFAULT_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  input  logic                        cfg_mode,
  output logic                        cfg_err,
  input  logic [N_CH-1:0]             ch_en,
  input  logic                        sync,
  output logic [N_CH-1:0]             clk_out,
  output logic [N_CH-1:0]             tick
);

  localparam int unsigned   CH_W     = ch_idx_w(N_CH);
  localparam logic [CH_W:0] N_CH_LIM = (CH_W + 1)'(N_CH);

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] wr_en;
  logic            ch_in_range;
  logic            accept;
  logic            div_nz;
  logic            cfg_err_q, cfg_err_d;

  assign ch_in_range = ({1'b0, cfg_ch} < N_CH_LIM);
  assign div_nz      = (cfg_div != '0);
  assign accept      = cfg_valid && cfg_ready;

  // Back-pressure only the targeted channel while its shadow is still waiting
  always_comb begin
    cfg_ready = 1'b0;
    if (rst_n) begin
      cfg_ready = ch_in_range ? !pending[cfg_ch] : 1'b1;
    end
  end

  // Zero divisor or a non-existent channel completes the handshake but is flagged
  always_comb begin
    cfg_err_d = accept && (!div_nz || !ch_in_range);
  end

  // One-cycle error strobe register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_en[i] = accept && div_nz && (cfg_ch == CH_W'(i));

    pulse_gen_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .sync    (sync),
      .wr_en   (wr_en[i]),
      .wr_div  (cfg_div),
      .wr_mode (mode_e'(cfg_mode)),
      .pending (pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_pulse_gen.sv
// tb/tb_prog_pulse_gen.sv - self-checking bench for prog_pulse_gen against a behavioural model
module tb_prog_pulse_gen;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int DDIV = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic            cfg_mode;
  logic            cfg_err;
  logic [NCH-1:0]  ch_en;
  logic            sync;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;

  int checks   = 0;
  int failures = 0;

  // model: position within the current period, active settings, waiting settings, outputs
  int m_pos    [NCH];
  int m_div    [NCH];
  int m_sh_div [NCH];
  bit m_pulse  [NCH];
  bit m_sh_pls [NCH];
  bit m_wait   [NCH];
  bit m_clk    [NCH];
  bit m_tick   [NCH];
  bit m_err;

  prog_pulse_gen #(
    .N_CH        (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .ch_en     (ch_en),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0; m_div[i] = DDIV; m_sh_div[i] = DDIV;
      m_pulse[i] = 0; m_sh_pls[i] = 0; m_wait[i] = 0;
      m_clk[i] = 0; m_tick[i] = 0;
    end
    m_err = 0;
  endfunction

  function automatic bit model_ready();
    return rst_n && !m_wait[cfg_ch];
  endfunction

  // One clock of behaviour: period bookkeeping, retune hand-over, then record any new request
  function automatic void model_step(input bit acc);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = acc && (cfg_div == 0);
    for (int i = 0; i < NCH; i++) begin
      bit done;
      bit old_pulse;
      old_pulse = m_pulse[i];
      done = 0;
      if (sync || !ch_en[i]) begin
        m_pos[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        if (m_wait[i]) begin
          m_div[i] = m_sh_div[i]; m_pulse[i] = m_sh_pls[i]; m_wait[i] = 0;
        end
      end else begin
        done = (m_pos[i] + 1 >= m_div[i]);
        m_tick[i] = done;
        if (done) begin
          m_pos[i] = 0;
          m_clk[i] = old_pulse ? 1'b1 : !m_clk[i];
          if (m_wait[i]) begin
            m_div[i] = m_sh_div[i]; m_pulse[i] = m_sh_pls[i]; m_wait[i] = 0;
            if (m_pulse[i] != old_pulse) m_clk[i] = 0;
          end
        end else begin
          m_pos[i] = m_pos[i] + 1;
          if (old_pulse) m_clk[i] = 0;
        end
      end
      if (acc && cfg_ch == i && cfg_div != 0) begin
        m_sh_div[i] = cfg_div; m_sh_pls[i] = cfg_mode; m_wait[i] = 1;
      end
    end
  endfunction

  task automatic cycle();
    bit acc;
    logic [NCH-1:0] e_clk, e_tick;
    #1;
    chk("cfg_ready", cfg_ready, model_ready());
    acc = cfg_valid && model_ready();
    @(posedge clk);
    model_step(acc);
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i]  = m_clk[i];
      e_tick[i] = m_tick[i];
    end
    chk("clk_out", clk_out, e_clk);
    chk("tick", tick, e_tick);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic cycles_to_tick(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick[ch] && n < 30);
  endtask

  initial begin
    int ntick;
    int n;
    model_reset();
    rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0;
    ch_en = '0; sync = 0;
    @(posedge clk); #1;
    run(2);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);

    // free-running at the reset divisor
    rst_n = 1; ch_en = 4'hF;
    ntick = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (tick[0]) ntick++;
    end
    chk("req039_ticks", ntick, 4);

    // retune ch1 to 3 mid-period
    cycle();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 3; cfg_mode = 0;
    cycle();
    cfg_valid = 0;
    #1;
    chk("req040_ready_low", cfg_ready, 0);
    run(12);

    // zero divisor is rejected
    cfg_valid = 1; cfg_ch = 2; cfg_div = 0;
    cycle();
    chk("req041_err", cfg_err, 1);
    cfg_valid = 0;
    cycle();
    chk("req041_err_clear", cfg_err, 0);
    run(12);

    // skew ch3 against ch0, then realign with sync
    ch_en[3] = 0;
    run(2);
    ch_en[3] = 1;
    run(5);
    sync = 1;
    cycle();
    sync = 0;
    run(4);
    chk("req042_coincident", tick & 4'b1001, 4'b1001);

    // ch0 to pulse mode, then gate and re-enable
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4; cfg_mode = 1;
    cycle();
    cfg_valid = 0; cfg_mode = 0;
    run(8);
    ch_en[0] = 0;
    cycle();
    chk("req043_off", {clk_out[0], tick[0]}, 0);
    run(3);
    ch_en[0] = 1;
    cycles_to_tick(0, n);
    chk("req043_first_tick", n, 4);

    // reset drops a pending shadow
    cfg_valid = 1; cfg_ch = 1; cfg_div = 6;
    cycle();
    cfg_valid = 0;
    rst_n = 0;
    cycle();
    chk("req044_outs", {clk_out, tick, cfg_err}, 0);
    rst_n = 1;
    #1;
    chk("req044_ready", cfg_ready, 1);
    cycles_to_tick(1, n);
    chk("req044_period", n, 4);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      sync      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom);
      cfg_div   = CW'($urandom_range(0, 6));
      cfg_mode  = 1'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_pulse_gen.md
PROG_PULSE_GEN -- requirements
Module: prog_pulse_gen

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32: divisor and counter width in bits.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 50_000_000: divisor loaded into every channel at reset (1 Hz square from 100 MHz).
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the block can accept the offered write.
REQ-008 The block SHALL have port cfg_ch, input, $clog2(N_CH) bits (min 1): target channel.
REQ-009 The block SHALL have port cfg_div, input, CNT_W bits: new divisor.
REQ-010 The block SHALL have port cfg_mode, input, 1 bit: 0 = square, 1 = pulse.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: one-cycle flag for a rejected write.
REQ-012 The block SHALL have port ch_en, input, N_CH bits: per-channel run enable.
REQ-013 The block SHALL have port sync, input, 1 bit: phase-align all channels.
REQ-014 The block SHALL have port clk_out, output, N_CH bits: per-channel divided output, registered.
REQ-015 The block SHALL have port tick, output, N_CH bits: per-channel one-cycle strobe at each counter wrap, registered.

Function
REQ-016 Each enabled channel SHALL count 0..div-1 and wrap to 0; a wrap is the cycle in which the counter equals div-1.
REQ-017 tick[i] SHALL be high for exactly the one cycle following each wrap, giving a period of div cycles.
REQ-018 In square mode, clk_out[i] SHALL toggle on each wrap (period 2*div); in pulse mode, clk_out[i] SHALL equal tick[i] (period div).
REQ-019 With div=1, tick SHALL stay high continuously, square-mode clk_out SHALL toggle every cycle, and pulse-mode clk_out SHALL stay 1.
REQ-020 A write SHALL be accepted on a cycle where cfg_valid && cfg_ready; cfg_ready SHALL equal !pending[cfg_ch] (combinational), and SHALL be 0 while rst_n is low.
REQ-021 An accepted write with cfg_div != 0 SHALL load a shadow {div, mode} and set pending[cfg_ch].
REQ-022 A pending shadow SHALL be applied at the channel's next wrap, clearing pending in that cycle; the wrap itself SHALL complete with the old divisor (glitch-free retune).
REQ-023 If the target channel is disabled, the shadow SHALL be applied one cycle after acceptance.
REQ-024 An accepted write with cfg_div == 0 SHALL complete the handshake, pulse cfg_err for one cycle, and leave the channel state and pending flag unchanged.
REQ-025 A mode change SHALL reset clk_out[i] to 0 at the moment it is applied.
REQ-026 When ch_en[i] is low, counter[i] SHALL be held at 0 and clk_out[i] and tick[i] SHALL be 0 from the next cycle.
REQ-027 On re-enable, the first tick SHALL occur div cycles later.
REQ-028 When sync is high, all counters and clk_out SHALL be cleared to 0 and all pending shadows applied, with no tick.
REQ-029 sync SHALL take priority over wrap and over enable.
REQ-030 Enabled channels of equal divisor SHALL then produce identical ticks.
REQ-031 A write accepted in the same cycle as its channel's wrap or sync SHALL go to the shadow and be applied at the following wrap.
REQ-032 The counter SHALL use unsigned CNT_W-bit arithmetic; the compare SHALL be counter >= div-1, so a counter above a newly applied smaller div wraps immediately.

Reset
REQ-033 When rst_n is low at a clk edge, the block SHALL set all counters to 0, clk_out=0, tick=0, cfg_err=0, pending=0, every div=DEFAULT_DIV, and every mode to square.
REQ-034 Reset mid-operation SHALL discard pending shadows.
REQ-035 Outputs SHALL become valid on the first edge after rst_n rises.

Structure
REQ-036 Package prog_pulse_gen_pkg SHALL hold the mode enum (MODE_SQUARE, MODE_PULSE), the DEFAULT_DIV constant, and the channel-index width helper.
REQ-037 One sub-module, pulse_gen_ch, SHALL implement a single channel (counter, shadow, pending, outputs).
REQ-038 The top level SHALL instantiate pulse_gen_ch N_CH times and SHALL contain the config decode, cfg_ready mux, and cfg_err register.

Verification (bench DEFAULT_DIV=4, N_CH=4)
REQ-039 Release reset, all ch_en=1 -> each tick SHALL pulse every 4 cycles, and each clk_out SHALL toggle every 4 cycles (period 8).
REQ-040 Write ch1 div=3 at count 1 -> the old period SHALL finish at count 3, then ticks every 3 cycles, with cfg_ready for ch1 low until the wrap.
REQ-041 Write ch2 div=0 -> cfg_err SHALL be high for 1 cycle, and ch2 period SHALL remain 4.
REQ-042 ch0 div=4, ch3 div=4 offset by 2 cycles, then sync for 1 cycle -> both ticks SHALL be coincident 4 cycles later.
REQ-043 Write ch0 pulse mode, then drop ch_en[0] mid-count -> clk_out[0]/tick[0] SHALL be 0 next cycle; re-enable -> first tick SHALL come after 4 cycles.
REQ-044 Pending write on ch1, then rst_n low for 1 cycle -> all outputs SHALL take reset values, pending SHALL clear, and ch1 div SHALL be 4.
